pchb_mux_n: RTL and testbench

Clocked, parametrised successor to the two-input dual-rail PCHB multiplexer in the async router datapath. It steers one of N dual-rail input channels, each W bits wide, to a single dual-rail output. The choice comes from a 1-of-N select channel, and every channel uses a four-phase return-to-zero handshake with active-high enables. Unlike the fixed two-channel, one-bit stage, this block detects illegal rail codes and latches them into a sticky error flag. It is the transistor-level mux's behavioural/synthesisable stand-in for router port selection.

---
 rtl/pchb_pkg.sv | 21 ++
 rtl/pchb_mux_n_dr_complete.sv | 32 +++
 rtl/pchb_mux_n.sv | 166 ++++++++++++++++
 tb/tb_pchb_mux_n.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pchb_pkg.sv
// rtl/pchb_pkg.sv - shared dual-rail constants, FSM state type and index helper
package pchb_pkg;

    // Dual-rail pair codes: rail 0 = false, rail 1 = true
    localparam logic [1:0] DR_NEUTRAL = 2'b00;
    localparam logic [1:0] DR_ZERO    = 2'b01;
    localparam logic [1:0] DR_ONE     = 2'b10;
    localparam logic [1:0] DR_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        RTZ  = 2'd2
    } pchb_state_t;

    // Width of a channel index; never zero so a 1-bit register still exists
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pchb_mux_n_dr_complete.sv
// rtl/pchb_mux_n_dr_complete.sv - combinational completion detector for a W-bit dual-rail bus
module dr_complete
    import pchb_pkg::*;
#(
    parameter int W = 1
) (
    input  logic [2*W-1:0] d,
    output logic           all_valid,
    output logic           all_neutral,
    output logic           any_illegal
);

    // Classify every pair; a bus is valid or neutral only if all its pairs agree
    always_comb begin
        all_valid   = 1'b1;
        all_neutral = 1'b1;
        any_illegal = 1'b0;
        for (int i = 0; i < W; i++) begin
            case (d[2*i +: 2])
                DR_NEUTRAL: all_valid = 1'b0;
                DR_ZERO,
                DR_ONE:     all_neutral = 1'b0;
                default: begin
                    all_valid   = 1'b0;
                    all_neutral = 1'b0;
                    any_illegal = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/pchb_mux_n.sv
// rtl/pchb_mux_n.sv - clocked N-input dual-rail PCHB multiplexer with sticky illegal-code flag
module pchb_mux_n
    import pchb_pkg::*;
#(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [N*2*W-1:0] L,
    output logic [N-1:0]     Le,
    input  logic [N-1:0]     SEL,
    output logic             SELe,
    output logic [2*W-1:0]   R,
    input  logic             Re,
    output logic             ERR
);

    localparam int KW = idx_width(N);

    pchb_state_t      state_q, state_d;
    logic [2*W-1:0]   r_q, r_d;
    logic [N-1:0]     le_q, le_d;
    logic             sele_q, sele_d;
    logic             err_q, err_d;
    logic [KW-1:0]    k_q, k_d;

    logic [N-1:0]     ch_valid;
    logic [N-1:0]     ch_neutral;
    logic [N-1:0]     ch_illegal;

    logic             sel_valid;
    logic             sel_neutral;
    logic             sel_illegal;
    logic [KW-1:0]    sel_idx;
    logic [2*W-1:0]   sel_data;
    logic             sel_ch_valid;
    logic             sel_ch_illegal;
    logic             k_neutral;

    logic             fire;
    logic             err_evt;
    logic             rtz_done;

    // One completion detector per input channel
    for (genvar g = 0; g < N; g++) begin : g_comp
        dr_complete #(.W(W)) u_comp (
            .d           (L[g*2*W +: 2*W]),
            .all_valid   (ch_valid[g]),
            .all_neutral (ch_neutral[g]),
            .any_illegal (ch_illegal[g])
        );
    end

    // 1-of-N select decode: population count, index encode and masked data mux
    always_comb begin
        int unsigned cnt;
        cnt      = 0;
        sel_idx  = '0;
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (SEL[i]) begin
                cnt      = cnt + 1;
                sel_idx  = KW'(i);
                sel_data = sel_data | L[i*2*W +: 2*W];
            end
        end
        sel_neutral = (cnt == 0);
        sel_valid   = (cnt == 1);
        sel_illegal = (cnt > 1);
    end

    // Status of the selected channel (SEL is one-hot whenever these are used)
    assign sel_ch_valid   = |(ch_valid & SEL);
    assign sel_ch_illegal = |(ch_illegal & SEL);

    // Neutrality of the latched channel; other channels are ignored after fire
    always_comb begin
        k_neutral = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (k_q == KW'(i)) begin
                k_neutral = ch_neutral[i];
            end
        end
    end

    assign fire     = (state_q == IDLE) && Re && sel_valid && sel_ch_valid;
    assign err_evt  = (state_q == IDLE) && Re &&
                      (sel_illegal || (sel_valid && sel_ch_illegal));
    assign rtz_done = sel_neutral && k_neutral;

    // State and output registers; reset drops any in-flight token
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            r_q     <= '0;
            le_q    <= '1;
            sele_q  <= 1'b1;
            err_q   <= 1'b0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            le_q    <= le_d;
            sele_q  <= sele_d;
            err_q   <= err_d;
            k_q     <= k_d;
        end
    end

    // Next-state logic for the four-phase handshake
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fire)     state_d = DATA;
            DATA:    if (!Re)      state_d = RTZ;
            RTZ:     if (rtz_done) state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs and the latched channel index
    always_comb begin
        r_d    = r_q;
        le_d   = le_q;
        sele_d = sele_q;
        err_d  = err_q;
        k_d    = k_q;
        case (state_q)
            IDLE: begin
                if (fire) begin
                    r_d    = sel_data;
                    le_d   = le_q & ~SEL;
                    sele_d = 1'b0;
                    k_d    = sel_idx;
                end
                if (err_evt) begin
                    err_d = 1'b1;
                end
            end
            DATA: begin
                if (!Re) begin
                    r_d = '0;
                end
            end
            RTZ: begin
                // Only Le[k] was lowered, so restoring all enables is equivalent
                if (rtz_done) begin
                    le_d   = '1;
                    sele_d = 1'b1;
                end
            end
            default: begin
                r_d    = '0;
                le_d   = '1;
                sele_d = 1'b1;
            end
        endcase
    end

    assign R    = r_q;
    assign Le   = le_q;
    assign SELe = sele_q;
    assign ERR  = err_q;

endmodule

// File: tb/tb_pchb_mux_n.sv
// tb/tb_pchb_mux_n.sv - self-checking bench for pchb_mux_n with a behavioural reference model
module tb_pchb_mux_n;

    localparam int N = 3;
    localparam int W = 2;
    localparam int CW = 2 * W;

    logic             CLK;
    logic             RESET;
    logic [N*CW-1:0]  L;
    logic [N-1:0]     Le;
    logic [N-1:0]     SEL;
    logic             SELe;
    logic [CW-1:0]    R;
    logic             Re;
    logic             ERR;

    logic             mon_valid;
    logic             mon_neutral;
    logic             mon_illegal;

    int               n_tests;
    int               n_fail;

    // Reference model state
    int               m_phase;   // 0 waiting, 1 holding data, 2 returning to zero
    int               m_k;
    logic [CW-1:0]    m_r;
    logic [N-1:0]     m_le;
    logic             m_sele;
    logic             m_err;

    pchb_mux_n #(.N(N), .W(W)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .L     (L),
        .Le    (Le),
        .SEL   (SEL),
        .SELe  (SELe),
        .R     (R),
        .Re    (Re),
        .ERR   (ERR)
    );

    dr_complete #(.W(W)) u_mon (
        .d           (R),
        .all_valid   (mon_valid),
        .all_neutral (mon_neutral),
        .any_illegal (mon_illegal)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [CW-1:0] chan(input int k);
        return L[k*CW +: CW];
    endfunction

    // 0 neutral, 1 valid, 2 illegal, 3 partial
    function automatic int chan_class(input logic [CW-1:0] c);
        int set_pairs;
        int bad_pairs;
        set_pairs = 0;
        bad_pairs = 0;
        for (int i = 0; i < W; i++) begin
            int p;
            p = int'(c[2*i +: 2]);
            if (p != 0) set_pairs++;
            if (p == 3) bad_pairs++;
        end
        if (bad_pairs > 0) return 2;
        if (set_pairs == 0) return 0;
        if (set_pairs == W) return 1;
        return 3;
    endfunction

    function automatic int onehot_index(input logic [N-1:0] s);
        int idx;
        idx = 0;
        for (int i = 0; i < N; i++) if (s[i]) idx = i;
        return idx;
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_k     = 0;
        m_r     = '0;
        m_le    = '1;
        m_sele  = 1'b1;
        m_err   = 1'b0;
    endtask

    // Advance the model by one clock using the inputs present at the edge
    task automatic model_update();
        int ones;
        int cls;
        int k;
        if (RESET) begin
            model_reset();
            return;
        end
        ones = $countones(SEL);
        case (m_phase)
            0: begin
                if (Re) begin
                    if (ones > 1) begin
                        m_err = 1'b1;
                    end else if (ones == 1) begin
                        k   = onehot_index(SEL);
                        cls = chan_class(chan(k));
                        if (cls == 2) begin
                            m_err = 1'b1;
                        end else if (cls == 1) begin
                            m_k       = k;
                            m_r       = chan(k);
                            m_le[k]   = 1'b0;
                            m_sele    = 1'b0;
                            m_phase   = 1;
                        end
                    end
                end
            end
            1: begin
                if (!Re) begin
                    m_r     = '0;
                    m_phase = 2;
                end
            end
            default: begin
                if (ones == 0 && chan_class(chan(m_k)) == 0) begin
                    m_le    = '1;
                    m_sele  = 1'b1;
                    m_phase = 0;
                end
            end
        endcase
    endtask

    task automatic step();
        @(posedge CLK);
        model_update();
        #1;
        check("R", 64'(R), 64'(m_r));
        check("Le", 64'(Le), 64'(m_le));
        check("SELe", 64'(SELe), 64'(m_sele));
        check("ERR", 64'(ERR), 64'(m_err));
        check("R_form", 64'({mon_valid | mon_neutral, mon_illegal}), 64'(2'b10));
    endtask

    task automatic close_handshake();
        Re = 1'b0;
        step();
        SEL = '0;
        L   = '0;
        step();
        Re = 1'b1;
    endtask

    function automatic logic [CW-1:0] rand_chan();
        logic [CW-1:0] c;
        int mode;
        mode = $urandom_range(0, 99);
        c = '0;
        for (int i = 0; i < W; i++) begin
            if (mode < 50)      c[2*i +: 2] = $urandom_range(0, 1) ? 2'b10 : 2'b01;
            else if (mode < 75) c[2*i +: 2] = 2'b00;
            else if (mode < 90) c[2*i +: 2] = 2'($urandom_range(0, 2));
            else                c[2*i +: 2] = 2'($urandom_range(0, 3));
        end
        return c;
    endfunction

    initial begin
        n_tests = 0;
        n_fail  = 0;
        model_reset();
        RESET = 1'b1;
        L     = '0;
        SEL   = '0;
        Re    = 1'b0;

        // Reset state
        step();
        step();
        check("rst_R", 64'(R), 64'(0));
        check("rst_Le", 64'(Le), 64'(3'b111));
        check("rst_SELe", 64'(SELe), 64'(1));
        check("rst_ERR", 64'(ERR), 64'(0));
        RESET = 1'b0;

        // Basic transfer from channel 0, then channel 1
        L   = {4'b0000, 4'b1010, 4'b0101};
        SEL = 3'b001;
        Re  = 1'b1;
        step();
        check("basic_R", 64'(R), 64'(4'b0101));
        check("basic_Le", 64'(Le), 64'(3'b110));
        check("basic_SELe", 64'(SELe), 64'(0));
        Re = 1'b0;
        step();
        check("basic_rtz_R", 64'(R), 64'(0));
        L   = {4'b0000, 4'b1010, 4'b0000};
        SEL = 3'b000;
        step();
        check("basic_en_Le", 64'(Le), 64'(3'b111));
        check("basic_en_SELe", 64'(SELe), 64'(1));
        SEL = 3'b010;
        Re  = 1'b1;
        step();
        check("basic2_R", 64'(R), 64'(4'b1010));
        check("basic2_Le", 64'(Le), 64'(3'b101));
        close_handshake();

        // Deep channel 2
        L   = {4'b1001, 4'b0000, 4'b0000};
        SEL = 3'b100;
        step();
        check("deep_R", 64'(R), 64'(4'b1001));
        check("deep_Le", 64'(Le), 64'(3'b011));
        close_handshake();

        // Partial data never fires
        L   = {4'b0000, 4'b0000, 4'b0001};
        SEL = 3'b001;
        for (int i = 0; i < 3; i++) step();
        check("partial_R", 64'(R), 64'(0));
        check("partial_Le", 64'(Le), 64'(3'b111));
        check("partial_ERR", 64'(ERR), 64'(0));
        L   = '0;
        SEL = '0;
        step();

        // Gating by Re
        L   = {4'b0000, 4'b0110, 4'b0000};
        SEL = 3'b010;
        Re  = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("gate_R", 64'(R), 64'(0));
        check("gate_Le", 64'(Le), 64'(3'b111));
        Re = 1'b1;
        step();
        check("gate_fire_R", 64'(R), 64'(4'b0110));
        check("gate_fire_Le", 64'(Le), 64'(3'b101));
        close_handshake();

        // Illegal select sets the sticky flag
        L   = {4'b0000, 4'b0101, 4'b0110};
        SEL = 3'b011;
        step();
        check("selerr_ERR", 64'(ERR), 64'(1));
        check("selerr_Le", 64'(Le), 64'(3'b111));
        check("selerr_R", 64'(R), 64'(0));
        SEL = '0;
        step();
        check("sticky_ERR", 64'(ERR), 64'(1));
        L   = {4'b0000, 4'b0000, 4'b1010};
        SEL = 3'b001;
        step();
        check("after_err_R", 64'(R), 64'(4'b1010));
        check("after_err_ERR", 64'(ERR), 64'(1));
        close_handshake();
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        check("clr_ERR", 64'(ERR), 64'(0));

        // Illegal pair on the selected channel
        L   = {4'b0011, 4'b0000, 4'b0000};
        SEL = 3'b100;
        step();
        check("pairerr_ERR", 64'(ERR), 64'(1));
        check("pairerr_Le", 64'(Le), 64'(3'b111));
        SEL   = '0;
        L     = '0;
        RESET = 1'b1;
        step();
        RESET = 1'b0;

        // Reset while holding data
        L   = {4'b0000, 4'b0000, 4'b1010};
        SEL = 3'b001;
        step();
        check("mid_R", 64'(R), 64'(4'b1010));
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        check("midrst_R", 64'(R), 64'(0));
        check("midrst_Le", 64'(Le), 64'(3'b111));
        check("midrst_SELe", 64'(SELe), 64'(1));
        SEL = '0;
        L   = '0;
        step();

        // Randomised traffic against the model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int sr;
            RESET = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 99) < 30) Re = ~Re;
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, 99) < 40) L[c*CW +: CW] = rand_chan();
            end
            sr = $urandom_range(0, 99);
            if (sr < 35)      SEL = N'(1) << $urandom_range(0, N - 1);
            else if (sr < 65) SEL = '0;
            else if (sr < 72) SEL = N'($urandom_range(0, (1 << N) - 1));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
